// File: rtl/featuremap_pkg.sv
// ============================================================================
//  Module      : featuremap_pkg
//  Description : Shared constants, FSM encoding and geometry helper for the
//                layer-1 featuremap input path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package featuremap_pkg;

    localparam logic [31:0] c_FP32_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    // Number of words in one zero-padded (width+2) x (width+2) frame.
    function automatic int unsigned padded_word_count(input int unsigned width);
        return (width + 2) * (width + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pad_position_counter.sv
// ============================================================================
//  Module      : pad_position_counter
//  Description : Raster row/col walker over the padded frame; flags border
//                positions and forms the unpadded frame-memory address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_position_counter
    import featuremap_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = $clog2(WIDTH + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    output logic                  is_pad,
    output logic                  is_last,
    output logic [ADDR_WIDTH-1:0] mem_addr
);

    localparam logic [CNT_WIDTH-1:0]  c_LAST    = CNT_WIDTH'(WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADR_W   = ADDR_WIDTH'(WIDTH);

    logic [CNT_WIDTH-1:0]  r_row;
    logic [CNT_WIDTH-1:0]  r_col;
    logic [ADDR_WIDTH-1:0] w_row_m1;
    logic [ADDR_WIDTH-1:0] w_col_m1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            if (r_col == c_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST) ? '0 : r_row + c_CNT_ONE;
            end else begin
                r_col <= r_col + c_CNT_ONE;
            end
        end
    end

    assign is_pad  = (r_row == '0) || (r_row == c_LAST) ||
                     (r_col == '0) || (r_col == c_LAST);
    assign is_last = (r_row == c_LAST) && (r_col == c_LAST);

    // Interior rows/cols are 1..WIDTH, so the -1 never underflows when used.
    assign w_row_m1 = ADDR_WIDTH'(r_row) - c_ADR_ONE;
    assign w_col_m1 = ADDR_WIDTH'(r_col) - c_ADR_ONE;
    assign mem_addr = is_pad ? '0 : (w_row_m1 * c_ADR_W) + w_col_m1;

endmodule

`default_nettype wire

// File: rtl/featuremap_pad_streamer.sv
// ============================================================================
//  Module      : featuremap_pad_streamer
//  Description : Streams a WIDTHxWIDTH {B,G,R} image from frame memory into
//                the featuremap FIFO as a zero-padded raster with backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module featuremap_pad_streamer
    import featuremap_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_rden,
    input  logic [DATA_WIDTH*3-1:0] mem_data,
    input  logic                    fifo_full,
    output logic [DATA_WIDTH*3-1:0] data_out,
    output logic                    data_fifo_wren,
    output logic                    busy,
    output logic                    done
);

    localparam logic [DATA_WIDTH*3-1:0] c_PAD_WORD = {3{DATA_WIDTH'(c_FP32_ZERO)}};

    fsm_state_t            r_state;
    fsm_state_t            w_state_next;
    logic                  w_clear;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_is_pad;
    logic                  w_is_last;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  r_out_valid;
    logic                  r_pad;

    pad_position_counter #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .advance  (w_issue),
        .is_pad   (w_is_pad),
        .is_last  (w_is_last),
        .mem_addr (w_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                end
            end
            ST_RUN: begin
                w_issue = !r_out_valid || !fifo_full;
                if (w_issue && w_is_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_out_valid) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The memory's own read register is the data half of the output stage: it
    // only advances on an issue, so it holds the pending word through a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_pad       <= 1'b0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_pad       <= w_is_pad;
        end else if (data_fifo_wren) begin
            r_out_valid <= 1'b0;
        end
    end

    assign mem_rden       = w_issue && !w_is_pad;
    assign mem_addr       = mem_rden ? w_addr : '0;
    assign data_out       = (r_out_valid && !r_pad) ? mem_data : c_PAD_WORD;
    assign data_fifo_wren = r_out_valid && !fifo_full;
    assign done           = w_done;
    assign busy           = (r_state == ST_RUN) || ((r_state == ST_DRAIN) && r_out_valid);

endmodule

`default_nettype wire

// File: tb/tb_featuremap_pad_streamer.sv
// ============================================================================
//  Module      : tb_featuremap_pad_streamer
//  Description : Self-checking bench for featuremap_pad_streamer at WIDTH=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_featuremap_pad_streamer;
    import featuremap_pkg::*;

    localparam int DW     = 32;
    localparam int W      = 4;
    localparam int AW     = 4;
    localparam int NWORDS = int'(padded_word_count(W));

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            fifo_full;
    logic [AW-1:0]   mem_addr;
    logic            mem_rden;
    logic [3*DW-1:0] mem_data = '0;
    logic [3*DW-1:0] data_out;
    logic            data_fifo_wren;
    logic            busy;
    logic            done;

    featuremap_pad_streamer #(
        .DATA_WIDTH (DW),
        .WIDTH      (W),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mem_addr       (mem_addr),
        .mem_rden       (mem_rden),
        .mem_data       (mem_data),
        .fifo_full      (fifo_full),
        .data_out       (data_out),
        .data_fifo_wren (data_fifo_wren),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3*DW-1:0] mem_word(input int a);
        return {DW'(a + 32'h200), DW'(a + 32'h100), DW'(a)};
    endfunction

    // Synchronous frame memory: output register only moves on a read.
    always @(posedge clk) if (mem_rden) mem_data <= mem_word(int'(mem_addr));

    typedef struct {
        int stall_mode;
        bit restart;
        bit exact_timing;
        int exp_writes;
        int exp_reads;
        int exp_first;
        int exp_last;
        int exp_done;
    } vec_t;

    vec_t vecs[4];

    logic [3*DW-1:0] exp_q[$];
    int              addr_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr, n_rd, n_done, first_wr, last_wr, done_cyc, t0;
    int cur_mode = 0;
    bit active = 1'b0;
    logic [3*DW-1:0] held;

    task automatic check(input bit ok, input string name,
                         input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit stall_at(input int mode, input int rel);
        case (mode)
            1: return (rel >= 5 && rel <= 9) || (rel > 9 && ((rel - 9) % 3) == 0);
            2: return (rel >= 2 && rel <= 101);
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (active) begin
            if (data_fifo_wren) begin
                check(fifo_full == 1'b0, "wren_while_full", 96'(fifo_full), 96'd0);
                n_wr++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (exp_q.size() == 0) begin
                    check(1'b0, "extra_write", data_out, '0);
                end else begin
                    logic [3*DW-1:0] e;
                    e = exp_q.pop_front();
                    check(data_out == e, "write_data", data_out, e);
                end
            end
            if (mem_rden) begin
                n_rd++;
                if (addr_q.size() == 0) begin
                    check(1'b0, "extra_read", 96'(mem_addr), '0);
                end else begin
                    int a;
                    a = addr_q.pop_front();
                    check(int'(mem_addr) == a, "read_addr", 96'(mem_addr), 96'(a));
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check(busy == 1'b0, "busy_at_done", 96'(busy), 96'd0);
            end
            if (cur_mode == 2 && (cyc - t0) == 2) held = data_out;
            if (cur_mode == 2 && (cyc - t0) > 2 && (cyc - t0) <= 101) begin
                check(data_out == held, "stuck_hold_data", data_out, held);
                check(mem_rden == 1'b0, "stuck_no_read", 96'(mem_rden), 96'd0);
            end
        end
    end

    task automatic build_expect();
        exp_q.delete();
        addr_q.delete();
        for (int r = 0; r < W + 2; r++) begin
            for (int c = 0; c < W + 2; c++) begin
                if (r == 0 || c == 0 || r == W + 1 || c == W + 1) begin
                    exp_q.push_back('0);
                end else begin
                    exp_q.push_back(mem_word((r - 1) * W + (c - 1)));
                    addr_q.push_back((r - 1) * W + (c - 1));
                end
            end
        end
    endtask

    task automatic run_frame(input vec_t v);
        build_expect();
        n_wr = 0; n_rd = 0; n_done = 0;
        first_wr = -1; last_wr = -1; done_cyc = -1;
        @(posedge clk); #1;
        t0        = cyc;
        cur_mode  = v.stall_mode;
        start     = 1'b1;
        fifo_full = stall_at(v.stall_mode, 0);
        active    = 1'b1;
        for (int k = 1; k < 700; k++) begin
            @(posedge clk); #1;
            start     = v.restart && ((cyc - t0) == 10);
            fifo_full = stall_at(v.stall_mode, cyc - t0);
            if (n_done > 0 && (cyc - done_cyc) >= 4) break;
        end
        start     = 1'b0;
        fifo_full = 1'b0;
        active    = 1'b0;
        cur_mode  = 0;
        check(n_done == 1, "done_count", 96'(n_done), 96'd1);
        check(n_wr == v.exp_writes, "write_count", 96'(n_wr), 96'(v.exp_writes));
        check(n_rd == v.exp_reads, "read_count", 96'(n_rd), 96'(v.exp_reads));
        check(exp_q.size() == 0, "words_missing", 96'(exp_q.size()), 96'd0);
        check(done_cyc > last_wr, "done_after_last", 96'(done_cyc), 96'(last_wr));
        if (v.exact_timing) begin
            check(first_wr - t0 == v.exp_first, "first_write_cyc", 96'(first_wr - t0), 96'(v.exp_first));
            check(last_wr - t0 == v.exp_last, "last_write_cyc", 96'(last_wr - t0), 96'(v.exp_last));
            check(done_cyc - t0 == v.exp_done, "done_cyc", 96'(done_cyc - t0), 96'(v.exp_done));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check(mem_addr == '0, {tag, "_mem_addr"}, 96'(mem_addr), '0);
        check(mem_rden == 1'b0, {tag, "_mem_rden"}, 96'(mem_rden), '0);
        check(data_out == '0, {tag, "_data_out"}, data_out, '0);
        check(data_fifo_wren == 1'b0, {tag, "_wren"}, 96'(data_fifo_wren), '0);
        check(busy == 1'b0, {tag, "_busy"}, 96'(busy), '0);
        check(done == 1'b0, {tag, "_done"}, 96'(done), '0);
    endtask

    initial begin
        // mode, restart, exact, writes, reads, first, last, done (cycles rel. to start)
        vecs[0] = '{0, 1'b0, 1'b1, NWORDS, W * W, 2, NWORDS + 1, NWORDS + 2};
        vecs[1] = '{1, 1'b0, 1'b0, NWORDS, W * W, 2, NWORDS + 1, NWORDS + 2};
        vecs[2] = '{0, 1'b1, 1'b1, NWORDS, W * W, 2, NWORDS + 1, NWORDS + 2};
        vecs[3] = '{2, 1'b0, 1'b0, NWORDS, W * W, 2, NWORDS + 1, NWORDS + 2};

        rst       = 1'b0;
        start     = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (6) @(posedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Asynchronous reset in the middle of a frame.
        repeat (3) @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while ((cyc - t0) < 15) begin
            @(posedge clk); #1;
        end
        check(busy && data_fifo_wren, "pre_reset_active", 96'({busy, data_fifo_wren}), 96'd3);
        rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(posedge clk); #1;
        check(done == 1'b0, "midreset_no_done", 96'(done), '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        run_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/featuremap_pad_streamer.md
# featuremap_pad_streamer

Producer side of the layer-1 featuremap input FIFO. On `start` it reads a WIDTH×WIDTH three-channel FP32 image from a synchronous frame memory and writes a zero-padded (WIDTH+2)×(WIDTH+2) raster stream of packed {B,G,R} words into the featuremap block's FIFO. The FIFO's `full` flag provides backpressure. The stream is row-major, one word per cycle when not stalled, and matches the padded geometry expected by the conv2D line buffers (WIDTH+2).

## Interface
- `DATA_WIDTH`, 32, width of one FP32 channel value
- `WIDTH`, 32, unpadded image width and height in pixels
- `ADDR_WIDTH`, 10, frame-memory address width; must satisfy 2^ADDR_WIDTH ≥ WIDTH*WIDTH

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to stream one frame; ignored unless idle
- `mem_addr`  out  ADDR_WIDTH  frame-memory read address
- `mem_rden`  out  1  frame-memory read enable
- `mem_data`  in  DATA_WIDTH*3  read data, valid exactly 1 cycle after `mem_rden`; R=[DW-1:0], G=[2DW-1:DW], B=[3DW-1:2DW]
- `fifo_full`  in  1  downstream FIFO full
- `data_out`  out  DATA_WIDTH*3  packed word to the FIFO
- `data_fifo_wren`  out  1  FIFO write strobe
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last word is written

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`.
  - RUN→DRAIN after the position (WIDTH+1, WIDTH+1) issues.
  - DRAIN→IDLE once the output register has been written. `done` pulses in that same transition cycle.
- Position counters: row, col ∈ [0, WIDTH+1]. col increments per issue and wraps to 0 with a row increment.
- A position is a border position if row or col equals 0 or WIDTH+1.
  - Border positions issue no memory read; they load 0 (all channels 32'h00000000).
  - Interior positions assert `mem_rden` with `mem_addr` = (row-1)*WIDTH + (col-1), computed at ADDR_WIDTH bits with no overflow by construction.
- Output register `out_valid`/`data_out`; `data_fifo_wren` = `out_valid` & ~`fifo_full`.
- Issue condition in RUN: ~`out_valid` | ~`fifo_full`, i.e. the register is empty or drains this cycle.
  - The word issued at t is loaded into the register at t+1: `mem_data`, or zero for a pad position (a pad flag is pipelined alongside).
  - If no issue occurs at t and the register drains, `out_valid` clears at t+1.
- Total words per frame: (WIDTH+2)². No word is dropped or duplicated under any `fifo_full` pattern.
- `start` during RUN/DRAIN is ignored.
- Async reset, mid-frame included: state=IDLE, counters=0, and all outputs go low/zero immediately. The partial frame is abandoned and no `done` is produced.

## Timing
- Reset values: `mem_addr`=0, `mem_rden`=0, `data_out`=0, `data_fifo_wren`=0, `busy`=0, `done`=0.
- `start` at cycle t → RUN and `busy` at t+1 → first issue at t+1 → first `data_fifo_wren` at t+2.
- Unstalled throughput: 1 word/cycle. The last word is written at t+1+(WIDTH+2)², and `done` pulses at t+2+(WIDTH+2)² with `busy` falling in the same cycle.
- Stall: while `fifo_full`=1 with `out_valid`=1, `data_out` holds and no new read issues. The address held by the memory is irrelevant because `mem_rden`=0.
- `fifo_full` is sampled combinationally in the same cycle as the write decision. The FIFO ignores writes when full, so `data_fifo_wren` is never asserted with `fifo_full`=1.

## Structure
- Shared package `featuremap_pkg`: FP32 zero constant, FSM state enum {IDLE, RUN, DRAIN}, and a function for padded-word count.
- One natural sub-module, `pad_position_counter`: row/col counters with advance enable, plus outputs `is_pad`, `is_last`, and `mem_addr`.

## Test plan
- WIDTH=4, memory word i = {i+0x200, i+0x100, i} (B,G,R), no stall, `start` at cycle 10. Required response:
  - 36 writes on cycles 12–47.
  - Words 0–6, 11, 12, 17, 18, 23, 24, 29, and 30–35 are zero; word 7 = memory word 0 and word 28 = memory word 15.
  - `done` at cycle 48.
- Same frame with `fifo_full` asserted on cycles 15–19 and every 3rd cycle thereafter → the identical 36-word sequence is received, `data_fifo_wren` is never high while `fifo_full` is high, and `done` arrives after the last write.
- `mem_rden` audit, WIDTH=4: exactly 16 reads, addresses 0..15 in order, with none issued for pad positions.
- `start` pulsed again at cycle 20 mid-frame → ignored; exactly 36 writes and one `done`.
- `rst` driven low at cycle 25 mid-frame → all outputs zero within the same cycle. A new `start` after release streams a complete 36-word frame beginning with address 0.
- `fifo_full` stuck high for 100 cycles starting at the first write → `data_out` is held constant and no `mem_rden` occurs. On release, streaming resumes with no loss.
